// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM for the MEM stage; stall_o is high for LATENCY cycles per access, then one DONE cycle returns load data.
// Optional DMEM_ERR_EN: misaligned requests are refused and flagged on adel_o/ades_o instead of being force-aligned.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        adel_o,
  output logic        ades_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic          store_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;

  logic [31:0]   mem [DEPTH];

  logic          in_idle;
  logic          req;
  logic          start;
  logic          is_byte_in;
  logic          is_half_in;
  logic [1:0]    off_in;

  assign in_idle    = (state_q == IDLE);
  assign req        = memread_i | memwrite_i;
  assign is_byte_in = (size_i == 2'b00);
  assign is_half_in = (size_i == 2'b01);

`ifdef DMEM_ERR_EN
  logic misaligned;
  assign misaligned = is_byte_in ? 1'b0 :
                      is_half_in ? addr_i[0] : (addr_i[1:0] != 2'b00);
  assign start  = req & ~misaligned;
  assign off_in = addr_i[1:0];
  assign adel_o = ~rst & in_idle & req & misaligned & ~memwrite_i;
  assign ades_o = ~rst & in_idle & req & misaligned & memwrite_i;
`else
  assign start  = req;
  assign off_in = is_byte_in ? addr_i[1:0] :
                  is_half_in ? {addr_i[1], 1'b0} : 2'b00;
  assign adel_o = 1'b0;
  assign ades_o = 1'b0;
`endif

  // The request cycle itself is the first stall cycle, so BUSY lasts LATENCY-1 cycles.
  assign stall_o = ~rst & ((state_q == BUSY) | (in_idle & start));
  assign rdata_o = rdata_q;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  // Operands seen at the edge entering DONE: live inputs when DONE follows IDLE directly.
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_off;
  logic [1:0]    acc_size;
  logic          acc_sign;
  logic          acc_store;

  assign acc_idx   = in_idle ? addr_i[AW+1:2] : idx_q;
  assign acc_off   = in_idle ? off_in         : off_q;
  assign acc_size  = in_idle ? size_i         : size_q;
  assign acc_sign  = in_idle ? sign_i         : sign_q;
  assign acc_store = in_idle ? memwrite_i     : store_q;

  always_comb begin
    rdata_d = 32'h0;
    if (!acc_store) begin
      rdata_d = load_extract(mem[acc_idx], acc_off, acc_size, acc_sign);
    end
  end

  logic [3:0]  wr_be;
  logic [31:0] wr_lane;

  always_comb begin
    wr_be   = 4'b1111;
    wr_lane = wdata_q;
    case (size_q)
      2'b00: begin
        wr_be   = 4'b0001 << off_q;
        wr_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = off_q[1] ? 4'b1100 : 4'b0011;
        wr_lane = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_lane = wdata_q;
      end
    endcase
  end

  // Stores commit only on the edge leaving DONE; an asynchronous reset before then drops them.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE && store_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[idx_q][8*b +: 8] <= wr_lane[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_q   <= addr_i[AW+1:2];
            off_q   <= off_in;
            wdata_q <= wdata_i;
            size_q  <= size_i;
            sign_q  <= sign_i;
            store_q <= memwrite_i;
            cnt_q   <= CNT_LOAD;
            if (CNT_LOAD == 4'd0) begin
              state_q <= DONE;
              rdata_q <= rdata_d;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
            rdata_q <= rdata_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the MEM-stage side of the pipeline control path.
- Consumes the memwriteM and memtoregM-qualified requests the pipeline issues; services them from an internal word-organised RAM with a configurable access latency.
- Returns load data for writeback and holds the pipeline with a stall output while an access is in flight.
- Handles byte, halfword and word sizes, with sign or zero extension on loads.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; address index is addr_i[$clog2(DEPTH)+1:2], upper address bits are ignored.
- LATENCY, 2, number of stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- memread_i  in  1  load request from the MEM stage.
- memwrite_i  in  1  store request from the MEM stage (memwriteM).
- addr_i  in  32  byte address (ALU result, MEM stage).
- wdata_i  in  32  store data, right-aligned.
- size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- sign_i  in  1  1 sign-extends sub-word loads, 0 zero-extends.
- rdata_o  out  32  load result, extended, right-aligned.
- stall_o  out  1  freeze the PC/IF/ID/EX/MEM registers while high.
- adel_o  out  1  misaligned load (DMEM_ERR_EN only).
- ades_o  out  1  misaligned store (DMEM_ERR_EN only).

Behaviour:
- Reset: state IDLE, counter 0, rdata_o 0, stall_o 0, adel_o/ades_o 0. RAM contents are not cleared.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If req = memread_i|memwrite_i and the access is legal: latch addr, wdata, size, sign and op; load counter = LATENCY-1; go to BUSY. stall_o = 1 combinationally in this cycle.
  - With no request: stall_o = 0 and the state stays IDLE.
- BUSY: stall_o = 1. Counter decrements each cycle. When the counter is 0, the next state is DONE.
- DONE:
  - stall_o = 0.
  - Store: byte lanes are committed at the rising edge that leaves DONE.
  - Load: rdata_o is valid for the whole DONE cycle and is captured by the MEM/WB register at that edge.
  - Next state is always IDLE. Inputs are ignored in DONE, because they still show the completing instruction.
- Stall count per access is exactly LATENCY cycles, then one DONE cycle. Back-to-back requests: the next access starts in the IDLE cycle after DONE.
- Latched operands are used for the whole access. Input changes during BUSY have no effect.
- Priority: memwrite_i and memread_i both high is treated as a store. The load returns 0.
- Store lane enables are derived from size and addr[1:0]:
  - byte: lane addr[1:0], data wdata[7:0] replicated.
  - half: lanes {addr[1],0} pair, data wdata[15:0].
  - word: all four lanes.
- Load extraction uses the same lanes, shifted to bit 0. Extension is by sign_i for byte and half; word is unaffected.
- Legality: a half access needs addr[0]==0; a word access needs addr[1:0]==0.
- Reset mid-access: returns to IDLE immediately. A store not yet in DONE is never committed, and stall_o drops asynchronously.
- rdata_o holds its last value outside DONE; it is registered.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - A misaligned request is not started. State stays IDLE, stall_o = 0, the RAM is unchanged.
  - adel_o (load) or ades_o (store) is asserted combinationally for the cycle the request is present.
- Undefined:
  - adel_o/ades_o are tied to 0.
  - Misaligned addresses are forced aligned by clearing addr[0] for half and addr[1:0] for word, and the access proceeds normally.

Test Plan:
- LATENCY=2. Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> each access shows stall_o high for exactly 2 cycles; the load returns rdata_o = 0xDEADBEEF in DONE.
- Store byte 0x80 to 0x13, then load byte from 0x13 with sign_i=1 -> 0xFFFFFF80; with sign_i=0 -> 0x00000080; word at 0x10 reads 0x80ADBEEF.
- Store half 0x1234 to 0x22, then load half signed from 0x22 -> 0x00001234; lanes 0 and 1 of word 0x20 are unchanged.
- Assert rst during BUSY of a store of 0x55 to 0x30 -> stall_o drops immediately; after reset, a load from 0x30 returns the old value.
- With DMEM_ERR_EN, load word from 0x31 -> adel_o = 1, stall_o = 0, no state change. Without the macro, the same load returns the word at 0x30 after LATENCY stalls.
- memread_i and memwrite_i both high, wdata 0xA5A5A5A5 to 0x40 -> treated as a store, rdata_o = 0; a subsequent load from 0x40 returns 0xA5A5A5A5.
